// File: rtl/ads8528_host_ctrl.sv
// Host-side controller for the ADS8528 parallel interface: config write, conversion
// start, BUSY handshake and an 8-word read frame streamed out with channel tags.
module ads8528_host_ctrl #(
  parameter int T_WRL        = 2,
  parameter int T_WRH        = 2,
  parameter int T_CONVST     = 2,
  parameter int T_RDL        = 3,
  parameter int T_RDH        = 2,
  parameter int BUSY_TIMEOUT = 1024,
  parameter int NUM_CH       = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cfg_start,
  input  logic [31:0] cfg_word,
  input  logic        conv_start,
  output logic        ready,
  output logic        cfg_done,
  output logic        CS_N,
  output logic        WR_N,
  output logic        RD_N,
  output logic        CONVST_A,
  output logic        CONVST_B,
  output logic        CONVST_C,
  output logic        CONVST_D,
  input  logic        BUSY,
  input  logic [15:0] DB_in,
  output logic [15:0] DB_out,
  output logic        DB_oe,
  output logic        sample_valid,
  output logic [15:0] sample_data,
  output logic [2:0]  sample_ch,
  output logic        frame_done,
  output logic        timeout_err
);

  localparam int MAX_T01 = (T_WRL > T_WRH) ? T_WRL : T_WRH;
  localparam int MAX_T23 = (T_CONVST > T_RDL) ? T_CONVST : T_RDL;
  localparam int MAX_T4  = (T_RDH > BUSY_TIMEOUT) ? T_RDH : BUSY_TIMEOUT;
  localparam int MAX_TA  = (MAX_T01 > MAX_T23) ? MAX_T01 : MAX_T23;
  localparam int MAX_T   = (MAX_TA > MAX_T4) ? MAX_TA : MAX_T4;
  localparam int CNT_W   = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {
    IDLE, WR_LO, WR_HI, CV_HI, WB_HI, WB_LO, RD_LO, RD_HI
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      cfg_reg;
  logic             w_reg;
  logic [2:0]       ch_reg;
  logic             busy_meta_reg;
  logic             busy_s_reg;
  logic             convst_reg;

  assign CONVST_A = convst_reg;
  assign CONVST_B = convst_reg;
  assign CONVST_C = convst_reg;
  assign CONVST_D = convst_reg;

  // BUSY comes straight from the ADC pin, so it is resynchronised before use.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_meta_reg <= 1'b0;
      busy_s_reg    <= 1'b0;
    end else begin
      busy_meta_reg <= BUSY;
      busy_s_reg    <= busy_meta_reg;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      cfg_reg      <= '0;
      w_reg        <= 1'b0;
      ch_reg       <= '0;
      ready        <= 1'b1;
      cfg_done     <= 1'b0;
      CS_N         <= 1'b1;
      WR_N         <= 1'b1;
      RD_N         <= 1'b1;
      convst_reg   <= 1'b0;
      DB_out       <= '0;
      DB_oe        <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      cfg_done     <= 1'b0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cfg_start) begin
            cfg_reg   <= cfg_word;
            w_reg     <= 1'b0;
            cnt_reg   <= CNT_W'(T_WRL - 1);
            ready     <= 1'b0;
            CS_N      <= 1'b0;
            WR_N      <= 1'b0;
            DB_oe     <= 1'b1;
            DB_out    <= cfg_word[31:16];
            state_reg <= WR_LO;
          end else if (conv_start) begin
            cnt_reg    <= CNT_W'(T_CONVST - 1);
            ready      <= 1'b0;
            convst_reg <= 1'b1;
            state_reg  <= CV_HI;
          end
        end
        WR_LO: begin
          if (cnt_reg == '0) begin
            cnt_reg   <= CNT_W'(T_WRH - 1);
            WR_N      <= 1'b1;
            state_reg <= WR_HI;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        WR_HI: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else if (!w_reg) begin
            w_reg     <= 1'b1;
            cnt_reg   <= CNT_W'(T_WRL - 1);
            WR_N      <= 1'b0;
            DB_out    <= cfg_reg[15:0];
            state_reg <= WR_LO;
          end else begin
            cfg_done  <= 1'b1;
            ready     <= 1'b1;
            CS_N      <= 1'b1;
            DB_oe     <= 1'b0;
            state_reg <= IDLE;
          end
        end
        CV_HI: begin
          if (cnt_reg == '0) begin
            cnt_reg    <= CNT_W'(BUSY_TIMEOUT - 1);
            convst_reg <= 1'b0;
            state_reg  <= WB_HI;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        WB_HI: begin
          if (busy_s_reg) begin
            cnt_reg   <= CNT_W'(BUSY_TIMEOUT - 1);
            state_reg <= WB_LO;
          end else if (cnt_reg == '0) begin
            timeout_err <= 1'b1;
            ready       <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        WB_LO: begin
          if (!busy_s_reg) begin
            ch_reg    <= '0;
            cnt_reg   <= CNT_W'(T_RDL - 1);
            CS_N      <= 1'b0;
            RD_N      <= 1'b0;
            state_reg <= RD_LO;
          end else if (cnt_reg == '0) begin
            timeout_err <= 1'b1;
            ready       <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        RD_LO: begin
          // Capture on the final low cycle so the ADC output delay has elapsed.
          if (cnt_reg == '0) begin
            sample_data  <= DB_in;
            sample_ch    <= ch_reg;
            sample_valid <= 1'b1;
            frame_done   <= (ch_reg == LAST_CH);
            RD_N         <= 1'b1;
            cnt_reg      <= CNT_W'(T_RDH - 1);
            state_reg    <= RD_HI;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        RD_HI: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else if (ch_reg != LAST_CH) begin
            ch_reg    <= ch_reg + 3'd1;
            cnt_reg   <= CNT_W'(T_RDL - 1);
            RD_N      <= 1'b0;
            state_reg <= RD_LO;
          end else begin
            CS_N      <= 1'b1;
            ready     <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ads8528_host_ctrl.sv
// Scoreboard bench for ads8528_host_ctrl: stimulus pushes expected writes/samples,
// a monitor branch pops and compares whenever the DUT presents them.
module tb_ads8528_host_ctrl;
  localparam int T_WRL        = 2;
  localparam int BUSY_TIMEOUT = 1024;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cfg_start = 1'b0;
  logic        conv_start = 1'b0;
  logic [31:0] cfg_word = '0;
  logic        BUSY = 1'b0;
  logic [15:0] DB_in;
  logic        ready, cfg_done, CS_N, WR_N, RD_N;
  logic        CONVST_A, CONVST_B, CONVST_C, CONVST_D;
  logic [15:0] DB_out;
  logic        DB_oe, sample_valid, frame_done, timeout_err;
  logic [15:0] sample_data;
  logic [2:0]  sample_ch;

  ads8528_host_ctrl dut (
    .CLK(CLK), .RST(RST), .cfg_start(cfg_start), .cfg_word(cfg_word),
    .conv_start(conv_start), .ready(ready), .cfg_done(cfg_done),
    .CS_N(CS_N), .WR_N(WR_N), .RD_N(RD_N),
    .CONVST_A(CONVST_A), .CONVST_B(CONVST_B), .CONVST_C(CONVST_C), .CONVST_D(CONVST_D),
    .BUSY(BUSY), .DB_in(DB_in), .DB_out(DB_out), .DB_oe(DB_oe),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ch(sample_ch),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  ch;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] wr_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rd_count = 0, convst_count = 0, cfg_done_count = 0, timeout_count = 0;
  logic [15:0] adc_words [8];
  logic [3:0]  rd_idx = '0;
  logic        busy_en = 1'b1;
  int          lat_meas = 0;

  // ADC model: word pointer restarts on CONVST and advances on each RD_N rise.
  assign DB_in = (!RD_N && !CS_N) ? adc_words[rd_idx[2:0]] : 16'hDEAD;

  always @(posedge CONVST_A or posedge RD_N) begin
    if (CONVST_A) rd_idx = '0;
    else          rd_idx = rd_idx + 4'd1;
  end

  always @(posedge CONVST_A) begin
    if (busy_en) begin
      int n;
      repeat (3) @(negedge CLK);
      BUSY = 1'b1;
      repeat (80) @(negedge CLK);
      BUSY = 1'b0;
      n = 0;
      while (RD_N && n < 20) begin
        @(negedge CLK);
        n++;
      end
      lat_meas = n;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic monitor();
    logic prev_rd = 1'b1, prev_wr = 1'b1, prev_cv = 1'b0;
    int   wr_low = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      check("no_wr_rd_overlap", {31'b0, !WR_N && !RD_N}, 32'd0);
      check("no_drive_during_read", {31'b0, DB_oe && !RD_N}, 32'd0);
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", {13'b0, sample_ch, sample_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sample_data", {16'b0, sample_data}, {16'b0, e.data});
          check("sample_ch", {29'b0, sample_ch}, {29'b0, e.ch});
          check("frame_done", {31'b0, frame_done}, {31'b0, e.last});
        end
      end else if (frame_done) begin
        check("frame_done_alone", 32'd1, 32'd0);
      end
      if (!WR_N && prev_wr) begin
        if (wr_q.size() == 0) check("unexpected_write", {16'b0, DB_out}, 32'hFFFF_FFFF);
        else check("wr_data", {16'b0, DB_out}, {16'b0, wr_q.pop_front()});
        check("wr_cs_n", {31'b0, CS_N}, 32'd0);
        check("wr_db_oe", {31'b0, DB_oe}, 32'd1);
        wr_low = 1;
      end else if (!WR_N) begin
        wr_low++;
      end else if (!prev_wr) begin
        check("wr_low_cycles", wr_low, T_WRL);
      end
      if (!RD_N && prev_rd) rd_count++;
      if (CONVST_A && !prev_cv) convst_count++;
      if (cfg_done) cfg_done_count++;
      if (timeout_err) timeout_count++;
      prev_rd = RD_N;
      prev_wr = WR_N;
      prev_cv = CONVST_A;
    end
  endtask

  task automatic pulse(input logic cfg, input logic conv);
    cfg_start  = cfg;
    conv_start = conv;
    @(negedge CLK);
    cfg_start  = 1'b0;
    conv_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!ready && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_returns_idle"}, {31'b0, ready}, 32'd1);
  endtask

  task automatic load_frame(input logic [15:0] w [8], input int nexp);
    exp_t e;
    adc_words = w;
    for (int i = 0; i < nexp; i++) begin
      e.data = w[i];
      e.ch   = 3'(i);
      e.last = (i == 7);
      exp_q.push_back(e);
    end
  endtask

  task automatic stimulus();
    int base, cv, n;
    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_strobes", {28'b0, CS_N, WR_N, RD_N, DB_oe}, 32'hE);
    check("rst_convst", {28'b0, CONVST_A, CONVST_B, CONVST_C, CONVST_D}, 32'h0);
    check("rst_db_out", {16'b0, DB_out}, 32'd0);
    check("rst_sample", {13'b0, sample_ch, sample_data}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // 1: config write
    wr_q.push_back(16'h2000);
    wr_q.push_back(16'h03FF);
    cfg_word = 32'h2000_03FF;
    pulse(1'b1, 1'b0);
    wait_idle("cfg1");
    repeat (2) @(negedge CLK);
    check("cfg1_done_count", cfg_done_count, 1);
    check("cfg1_writes_left", wr_q.size(), 0);
    check("cfg1_no_reads", rd_count, 0);
    check("cfg1_cs_n_idle", {31'b0, CS_N}, 32'd1);

    // 2: normal conversion frame
    load_frame('{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                 16'h0005, 16'h0006, 16'h0007, 16'h0008}, 8);
    base = rd_count;
    pulse(1'b0, 1'b1);
    check("conv_latency", {28'b0, CONVST_A, CONVST_B, CONVST_C, CONVST_D}, 32'hF);
    wait_idle("frame2");
    repeat (2) @(negedge CLK);
    check("frame2_rd_pulses", rd_count - base, 8);
    check("frame2_samples_left", exp_q.size(), 0);
    check("busy_fall_to_rd_cycles", lat_meas, 3);

    // 3: BUSY never rises
    busy_en = 1'b0;
    base = rd_count;
    pulse(1'b0, 1'b1);
    n = 0;
    while (CONVST_A && n < 20) begin
      @(negedge CLK);
      n++;
    end
    n = 0;
    while (!timeout_err && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("timeout_cycles", n, BUSY_TIMEOUT);
    check("timeout_ready", {31'b0, ready}, 32'd1);
    repeat (2) @(negedge CLK);
    check("timeout_count", timeout_count, 1);
    check("timeout_no_reads", rd_count - base, 0);
    busy_en = 1'b1;

    // 4: simultaneous starts, then conv_start during a frame
    wr_q.push_back(16'hA5A5);
    wr_q.push_back(16'h5A5A);
    cfg_word = 32'hA5A5_5A5A;
    cv = convst_count;
    pulse(1'b1, 1'b1);
    wait_idle("cfg4");
    repeat (3) @(negedge CLK);
    check("both_start_no_convst", convst_count - cv, 0);
    check("both_start_cfg_done", cfg_done_count, 2);
    check("both_start_writes_left", wr_q.size(), 0);
    load_frame('{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                 16'h5555, 16'h6666, 16'h7777, 16'h8888}, 8);
    pulse(1'b0, 1'b1);
    n = 0;
    while (RD_N && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("frame4_read_started", {31'b0, RD_N}, 32'd0);
    pulse(1'b0, 1'b1);
    wait_idle("frame4");
    repeat (5) @(negedge CLK);
    check("conv_during_read_ignored", convst_count - cv, 1);
    check("frame4_samples_left", exp_q.size(), 0);

    // 5: reset during the 4th RD_LO
    load_frame('{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                 16'h0005, 16'h0006, 16'h0007, 16'h0008}, 3);
    base = rd_count;
    pulse(1'b0, 1'b1);
    n = 0;
    while (rd_count < base + 4 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("rst5_in_read", {31'b0, RD_N}, 32'd0);
    RST = 1'b1;
    #1;
    check("rst5_strobes", {28'b0, CS_N, WR_N, RD_N, DB_oe}, 32'hE);
    check("rst5_ready", {31'b0, ready}, 32'd1);
    check("rst5_sample", {13'b0, sample_ch, sample_data}, 32'd0);
    check("rst5_pulses", {29'b0, sample_valid, frame_done, timeout_err}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rst5_samples_before_abort", exp_q.size(), 0);
    load_frame('{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                 16'h0005, 16'h0006, 16'h0007, 16'h0008}, 8);
    base = rd_count;
    pulse(1'b0, 1'b1);
    wait_idle("frame5");
    repeat (2) @(negedge CLK);
    check("frame5_rd_pulses", rd_count - base, 8);
    check("frame5_samples_left", exp_q.size(), 0);

    // 6: extreme codes pass through unchanged
    load_frame('{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000,
                 16'h8001, 16'hFFFE, 16'h0123, 16'hFEDC}, 8);
    pulse(1'b0, 1'b1);
    wait_idle("frame6");
    repeat (2) @(negedge CLK);
    check("frame6_samples_left", exp_q.size(), 0);
    check("final_writes_left", wr_q.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
